// File: rtl/imem_load_ctrl.sv
// Instruction-memory program loader: takes a (base, count) load command, streams
// host words over valid/ready into the imem write port and stalls fetch meanwhile.
module imem_load_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_wraddr,
    output logic [DATA_WIDTH-1:0] imem_wrdata,
    output logic                  core_stall,
    output logic                  done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_written
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH+1:0] DEPTH_EXT = (ADDR_WIDTH+2)'(DATA_DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q;

    logic [ADDR_WIDTH+1:0] load_end;
    logic [ADDR_WIDTH:0]   next_written;
    logic                  accept;
    logic                  last_word;

    // Two extra bits so base+count can never overflow before the range compare.
    assign load_end     = {2'b00, base_addr} + {1'b0, word_count};
    assign in_ready     = (state == LOAD) && !abort;
    assign accept       = in_valid && in_ready;
    assign next_written = words_written + 1'b1;
    assign last_word    = (next_written == count_q);

    // NOTE: all state below is sequential, so every assignment is non-blocking;
    // mixing in blocking assignments here would create ordering-dependent races.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            base_q        <= '0;
            count_q       <= '0;
            imem_wren     <= 1'b0;
            imem_wraddr   <= '0;
            imem_wrdata   <= '0;
            core_stall    <= 1'b0;
            done          <= 1'b0;
            load_error    <= 1'b0;
            words_written <= '0;
        end else begin
            // NOTE: one-cycle pulses get a default of 0 at the top so that no
            // branch can leave them stuck high.
            imem_wren <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q        <= base_addr;
                        count_q       <= word_count;
                        words_written <= '0;
                        load_error    <= 1'b0;
                        core_stall    <= 1'b1;
                        if (load_end > DEPTH_EXT) begin
                            load_error <= 1'b1;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else if (word_count == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (abort) begin
                        // A write accepted last cycle is already on the port and completes.
                        load_error <= 1'b1;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else if (accept) begin
                        imem_wren     <= 1'b1;
                        imem_wraddr   <= base_q + words_written[ADDR_WIDTH-1:0];
                        imem_wrdata   <= in_data;
                        words_written <= next_written;
                        if (last_word) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    done  <= 1'b1;
                    state <= DONE;
                end

                DONE: begin
                    core_stall <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
